instruction_fetch_stage: RTL

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

---
 rtl/instruction_fetch_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: drives a single-outstanding request to instruction
// memory, registers the returned word for decode, and buffers one word while
// decode is stalled. Branch redirect and flush override stall and ack.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | one cycle after reset, no request issued
// FETCH | request outstanding at imem_addr, waiting for imem_ack
// HOLD  | fetched word parked in hold buffer, waiting for stall to drop
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm16
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & WORD_MASK;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] hold_instr, hold_instr_n;
    logic [31:0] hold_addr, hold_addr_n;
    logic        id_valid_n;
    logic [31:0] id_instr_n;
    logic [31:0] id_pc_plus4_n;

    // Request is only issued while waiting on memory; address is the PC.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    // Decode field slices of the registered instruction.
    assign id_opcode = id_instr[31:26];
    assign id_rs     = id_instr[25:21];
    assign id_rt     = id_instr[20:16];
    assign id_rd     = id_instr[15:11];
    assign id_shamt  = id_instr[10:6];
    assign id_funct  = id_instr[5:0];
    assign id_imm16  = id_instr[15:0];

    // Next-state and datapath update; priority is redirect, flush, stall, ack.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        hold_instr_n  = hold_instr;
        hold_addr_n   = hold_addr;
        id_valid_n    = id_valid;
        id_instr_n    = id_instr;
        id_pc_plus4_n = id_pc_plus4;

        if (branch_taken) begin
            pc_n         = branch_target & WORD_MASK;
            id_valid_n   = 1'b0;
            hold_instr_n = 32'h0000_0000;
            hold_addr_n  = 32'h0000_0000;
            state_n      = FETCH;
        end else if (flush) begin
            id_valid_n   = 1'b0;
            hold_instr_n = 32'h0000_0000;
            hold_addr_n  = 32'h0000_0000;
            state_n      = FETCH;
        end else begin
            case (state)
                IDLE: begin
                    state_n = FETCH;
                end
                FETCH: begin
                    if (stall) begin
                        if (imem_ack) begin
                            hold_instr_n = imem_rdata;
                            hold_addr_n  = pc;
                            pc_n         = pc + 32'd4;
                            state_n      = HOLD;
                        end
                    end else if (imem_ack) begin
                        id_instr_n    = imem_rdata;
                        id_pc_plus4_n = pc + 32'd4;
                        id_valid_n    = 1'b1;
                        pc_n          = pc + 32'd4;
                    end else begin
                        id_valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        id_instr_n    = hold_instr;
                        id_pc_plus4_n = hold_addr + 32'd4;
                        id_valid_n    = 1'b1;
                        state_n       = FETCH;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC_ALIGNED;
            hold_instr  <= 32'h0000_0000;
            hold_addr   <= 32'h0000_0000;
            id_valid    <= 1'b0;
            id_instr    <= 32'h0000_0000;
            id_pc_plus4 <= 32'h0000_0000;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            hold_instr  <= hold_instr_n;
            hold_addr   <= hold_addr_n;
            id_valid    <= id_valid_n;
            id_instr    <= id_instr_n;
            id_pc_plus4 <= id_pc_plus4_n;
        end
    end

endmodule
